// File: rtl/decode_writeback_if.sv
// decode_writeback_if
//   Bundles the decode/write-back stage's fetch, execute and memory inputs
//   with its decode, register-read, status and retire outputs.
//   master : the surrounding core (drives fetch/execute/memory fields and wb_en)
//   slave  : the decode_writeback stage
//   Signals: icode, rA, rB, instr_valid, imem_error, cnd, valE, valM, wb_en (to stage)
//            srcA, srcB, dstE, dstM, valA, valB, stat, retired (from stage)
interface decode_writeback_if;
  logic [3:0]  icode;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic        instr_valid;
  logic        imem_error;
  logic        cnd;
  logic [63:0] valE;
  logic [63:0] valM;
  logic        wb_en;
  logic [3:0]  srcA;
  logic [3:0]  srcB;
  logic [3:0]  dstE;
  logic [3:0]  dstM;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [1:0]  stat;
  logic [31:0] retired;

  modport master (
    output icode, rA, rB, instr_valid, imem_error, cnd, valE, valM, wb_en,
    input  srcA, srcB, dstE, dstM, valA, valB, stat, retired
  );

  modport slave (
    input  icode, rA, rB, instr_valid, imem_error, cnd, valE, valM, wb_en,
    output srcA, srcB, dstE, dstM, valA, valB, stat, retired
  );
endinterface

// File: rtl/decode_writeback.sv
// decode_writeback
//   Decode and write-back stage of the sequential Y86-64 core. Decodes register
//   IDs from icode/rA/rB/cnd, reads the 15-entry 64-bit register file with zero
//   latency (no bypass), commits valE/valM on the rising edge when wb_en is set
//   and the core is still AOK, latches a sticky halt/fault status and counts
//   retired instructions.
//   Ports:
//     clk  - system clock, rising edge
//     rst  - asynchronous active-high reset
//     dw   - decode_writeback_if.slave (fetch/execute/memory inputs, decode,
//            read, stat and retired outputs)
module decode_writeback #(
  parameter logic [63:0] STACK_INIT = 64'd1024,
  parameter logic [3:0]  RNONE      = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  decode_writeback_if.slave dw
);

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_INS = 2'd2;
  localparam logic [1:0] STAT_ADR = 2'd3;
  localparam logic [3:0] REG_RSP  = 4'd4;

  logic [63:0] regs [0:14];
  logic [1:0]  stat_q;
  logic [31:0] retired_q;

  logic [3:0]  src_a, src_b, dst_e, dst_m;
  logic [1:0]  new_stat;
  logic        commit;

  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    if (dw.instr_valid && !dw.imem_error) begin
      unique case (dw.icode)
        4'h2: begin
          src_a = dw.rA;
          dst_e = dw.cnd ? dw.rB : RNONE;
        end
        4'h3: dst_e = dw.rB;
        4'h4: begin
          src_a = dw.rA;
          src_b = dw.rB;
        end
        4'h5: begin
          src_b = dw.rB;
          dst_m = dw.rA;
        end
        4'h6: begin
          src_a = dw.rA;
          src_b = dw.rB;
          dst_e = dw.rB;
        end
        4'h8: begin
          src_b = REG_RSP;
          dst_e = REG_RSP;
        end
        4'h9: begin
          src_a = REG_RSP;
          src_b = REG_RSP;
          dst_e = REG_RSP;
        end
        4'hA: begin
          src_a = dw.rA;
          src_b = REG_RSP;
          dst_e = REG_RSP;
        end
        4'hB: begin
          src_a = REG_RSP;
          src_b = REG_RSP;
          dst_e = REG_RSP;
          dst_m = dw.rA;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    new_stat = STAT_AOK;
    if (dw.imem_error)
      new_stat = STAT_ADR;
    else if (!dw.instr_valid)
      new_stat = STAT_INS;
    else if (dw.icode == 4'h0)
      new_stat = STAT_HLT;
  end

  assign commit = dw.wb_en && (stat_q == STAT_AOK);

  assign dw.srcA    = src_a;
  assign dw.srcB    = src_b;
  assign dw.dstE    = dst_e;
  assign dw.dstM    = dst_m;
  assign dw.valA    = (src_a == RNONE) ? '0 : regs[src_a];
  assign dw.valB    = (src_b == RNONE) ? '0 : regs[src_b];
  assign dw.stat    = stat_q;
  assign dw.retired = retired_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 15; i++)
        regs[i] <= (i == 32'(REG_RSP)) ? STACK_INIT : '0;
      stat_q    <= STAT_AOK;
      retired_q <= '0;
    end else if (commit) begin
      stat_q <= new_stat;
      if (new_stat == STAT_AOK) begin
        if (dst_e != RNONE)
          regs[dst_e] <= valE_q_unused_guard(dw.valE);
        // M write is issued last so it overrides E when both target the
        // same register (popq %rsp).
        if (dst_m != RNONE)
          regs[dst_m] <= dw.valM;
      end
      if (new_stat == STAT_AOK || new_stat == STAT_HLT)
        retired_q <= retired_q + 32'd1;
    end
  end

  function automatic logic [63:0] valE_q_unused_guard(input logic [63:0] v);
    return v;
  endfunction

endmodule

// File: doc/decode_writeback.md
Name: decode_writeback

Overview:
- Decode and write-back stage of the sequential Y86-64 core; sits directly downstream of the instruction fetch stage.
- Consumes icode, rA, rB, instr_valid and imem_error from fetch, and cnd, valE and valM from execute/memory.
- Owns the 15-entry 64-bit register file: produces srcA/srcB/dstE/dstM and valA/valB, and commits results on the clock edge.
- Also latches a halt/fault status and counts retired instructions.

Parameters:
- STACK_INIT, 64'd1024, reset value of %rsp (register 4); all other registers reset to 0.
- RNONE, 4'hF, register ID meaning "no register".

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous active-high reset
- icode  input  4  instruction code from fetch
- rA  input  4  register A field from fetch
- rB  input  4  register B field from fetch
- instr_valid  input  1  fetch decoded a legal icode
- imem_error  input  1  fetch address out of range
- cnd  input  1  condition result from execute (used by cmovXX)
- valE  input  64  ALU result
- valM  input  64  data-memory read result
- wb_en  input  1  commit strobe: this cycle's instruction is complete and may write back
- srcA  output  4  decoded source A register ID
- srcB  output  4  decoded source B register ID
- dstE  output  4  decoded E-port destination ID
- dstM  output  4  decoded M-port destination ID
- valA  output  64  register-file read of srcA
- valB  output  64  register-file read of srcB
- stat  output  2  0=AOK, 1=HLT, 2=INS (invalid instruction), 3=ADR (memory address error)
- retired  output  32  count of committed instructions

Behaviour:
- Reset is asynchronous and active-high. On rst high, immediately and independent of clk:
  - all registers 0, except reg[4]=STACK_INIT;
  - stat=AOK;
  - retired=0.
- Asserting rst mid-operation discards any pending write.

Decode (combinational, from icode/rA/rB/cnd):
- srcA: icode 2,4,6,A -> rA; icode 9,B -> 4; otherwise RNONE.
- srcB: icode 4,5,6 -> rB; icode 8,9,A,B -> 4; otherwise RNONE.
- dstE:
  - icode 2 -> rB if cnd=1, else RNONE;
  - icode 3,6 -> rB;
  - icode 8,9,A,B -> 4;
  - otherwise RNONE.
- dstM: icode 5,B -> rA; otherwise RNONE.
- When instr_valid=0 or imem_error=1, all four IDs are forced to RNONE.

Register read (combinational, zero latency):
- valA = reg[srcA] and valB = reg[srcB]; an ID of RNONE reads as 64'd0.
- There is no write-to-read bypass: a read in the same cycle as a write returns the old value, and the new value is visible after the edge.

Write-back (rising edge of clk), only when wb_en=1 and stat=AOK:
- if dstE != RNONE, reg[dstE] <= valE;
- if dstM != RNONE, reg[dstM] <= valM;
- if dstE == dstM and both are valid (popq %rsp), the M port wins and reg = valM.

Status and retire counter (rising edge of clk, evaluated when wb_en=1 and stat=AOK):
- Priority for the new status: imem_error -> ADR, else !instr_valid -> INS, else icode==0 -> HLT, else AOK.
- Once stat != AOK it is sticky until rst. While stat != AOK:
  - all writes are suppressed;
  - retired freezes.
- retired increments by 1 (wrapping modulo 2^32) on every edge where wb_en=1 and the instruction commits with AOK, or is the halt itself (halt counts as retired). Faulting instructions (INS/ADR) do not count and do not write.
- wb_en=0: no state change; decode and read outputs still track the inputs.

Test Plan:
- Reset: assert rst asynchronously between edges -> immediately reg[4]=1024, all other registers 0 (read via srcA), stat=0, retired=0.
- irmovq: icode=3, rB=2, valE=0x1234, wb_en=1 -> after the edge, reading reg2 gives 0x1234, dstE=2 before the edge, retired=1.
- cmov both cases: icode=2, rA=1, rB=3, cnd=0, valE=7 -> dstE=F, reg3 unchanged. Repeat with cnd=1 -> reg3=7.
- popq %rsp: icode=B, rA=4, valE=1032, valM=0xAA, wb_en=1 -> reg4=0xAA (M wins); srcA=srcB=4 beforehand.
- Read-during-write: OPq with rA=rB=5, reg5=10, valE=20 -> valA=valB=10 during the cycle, 20 after the edge.
- Faults:
  - instr_valid=0 with wb_en=1 -> stat=2, retired unchanged, and no writes on later edges despite wb_en;
  - separately, icode=0 -> stat=1 and retired incremented once, then frozen;
  - rst clears both cases to AOK.
